reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive lost unit cycles before pipe_hold is raised (legal 1..15).
REQ-002 clk  in  1  single clock; all state on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pipe_we  in  1  pipeline writeback valid; cannot be back-pressured.
REQ-005 pipe_rd, pipe_data, pipe_pc  in  5/32/32  pipeline destination, value, instruction PC.
REQ-006 unit_valid  in  1; unit_ready  out  1  long-latency unit result handshake.
REQ-007 unit_rd, unit_data, unit_pc  in  5/32/32  unit destination, value, PC.
REQ-008 issue_valid, issue_rd  in  1/5  unit accepted an op writing issue_rd.
REQ-009 rs0, rs1  in  5; rs0_busy, rs1_busy  out  1  scoreboard lookup for decode-stage sources.
REQ-010 pipe_hold  out  1  request to the pipeline to present no writeback this cycle.
REQ-011 wr_en, wr_num, wr_data, wr_pc  out  1/5/32/32  register file write port (regWriteEnable, regWriteNum, regWriteData) plus trace PC.
REQ-012 err_sticky  out  1  protocol violation flag.

Function
REQ-013 The block SHALL treat a pipeline write as live only when pipe_we=1 and pipe_rd!=0; writes to x0 SHALL be dropped and SHALL NOT consume the port.
REQ-014 unit_ready SHALL be combinational: 1 exactly when no live pipeline write is present this cycle; it SHALL NOT depend on unit_valid.
REQ-015 A unit transfer SHALL occur in a cycle with unit_valid=1 and unit_ready=1; unit_rd/data/pc SHALL be held stable by the unit until transfer.
REQ-016 Priority SHALL be fixed: live pipeline write first, unit transfer second; at most one write per cycle.
REQ-017 The winner SHALL appear on wr_* registered, one cycle after the winning cycle; wr_en SHALL be 1 for exactly that cycle, 0 otherwise.
REQ-018 A unit transfer with unit_rd=0 SHALL complete the handshake but produce wr_en=0.
REQ-019 wr_num/wr_data/wr_pc SHALL hold their last values while wr_en=0.
REQ-020 Counter wait_cnt (4 bits) SHALL increment on each cycle with unit_valid=1 and unit_ready=0, and clear on unit transfer or unit_valid=0.
REQ-021 pipe_hold SHALL be registered and assert for exactly one cycle following a losing cycle in which wait_cnt=STARVE_LIMIT-1; wait_cnt SHALL clear in that same update.
REQ-022 If a live pipeline write arrives while pipe_hold=1, the pipeline write SHALL still win and err_sticky SHALL set.
REQ-023 Scoreboard busy[31:1] SHALL set bit issue_rd on issue_valid=1 with issue_rd!=0, and clear bit unit_rd on a unit transfer with unit_rd!=0.
REQ-024 Simultaneous set and clear of the same bit SHALL leave it set (set wins); issue to an already busy register SHALL leave it busy.
REQ-025 rsN_busy SHALL be combinational from the registered busy vector: busy[rsN] when rsN!=0, else 0; a clear becomes visible the cycle wr_en writes the value.
REQ-026 A live pipeline write to a register whose busy bit is set SHALL still be performed and SHALL set err_sticky (WAW hazard).
REQ-027 err_sticky SHALL remain 1 until reset.

Reset
REQ-028 On reset low, asynchronously: wr_en=0, wr_num=0, wr_data=0, wr_pc=0, pipe_hold=0, err_sticky=0, wait_cnt=0, busy=0.
REQ-029 Reset mid-operation SHALL discard any pending registered write; a unit transfer in the reset cycle SHALL be lost, and unit_ready SHALL keep following REQ-014.
REQ-030 Normal operation SHALL resume on the first posedge with reset high.

Verification
REQ-031 Pipeline only: pipe_we=1, rd=5, data=0xDEADBEEF, pc=0x100 at cycle T -> wr_en=1, wr_num=5, wr_data=0xDEADBEEF, wr_pc=0x100 at T+1.
REQ-032 Collision: pipe write x3 and unit_valid x7 in the same cycle -> unit_ready=0, x3 written at T+1; unit transfers the next free cycle, x7 written one cycle later.
REQ-033 Starvation: unit_valid held, live pipe writes every cycle, STARVE_LIMIT=4 -> pipe_hold=1 for one cycle after the 4th loss; pipeline idles, unit transfers in the hold cycle; err_sticky stays 0.
REQ-034 Scoreboard: issue x9 at T -> rs0=9 gives rs0_busy=1 from T+1; unit transfer x9 at U -> rs0_busy=0 and wr_en=1, wr_num=9 at U+1; rs0=0 always gives 0.
REQ-035 Errors: pipe write to busy x9 -> err_sticky=1; pipe write during pipe_hold -> err_sticky=1; pipe write to x0 -> no wr_en and unit_ready stays 1.
REQ-036 Reset: assert reset low mid-transfer with busy bits set -> all REQ-028 values immediately, no wr_en after release.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges pipeline writeback and long-latency unit results onto one
// register-file write port, with starvation relief and a pending-write scoreboard.
module reg_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    input  logic        unit_valid,
    output logic        unit_ready,
    input  logic [4:0]  unit_rd,
    input  logic [31:0] unit_data,
    input  logic [31:0] unit_pc,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs0,
    input  logic [4:0]  rs1,
    output logic        rs0_busy,
    output logic        rs1_busy,
    output logic        pipe_hold,
    output logic        wr_en,
    output logic [4:0]  wr_num,
    output logic [31:0] wr_data,
    output logic [31:0] wr_pc,
    output logic        err_sticky
);

    localparam logic [3:0] HOLD_AT = 4'(STARVE_LIMIT - 1);

    logic        pipeLive;
    logic        unitXfer;
    logic        unitLoses;
    logic [3:0]  waitCnt;
    logic [31:0] busy;
    logic [31:0] busyNext;

    // Writes to x0 are dropped entirely and leave the port free for the unit.
    assign pipeLive   = pipe_we && (pipe_rd != 5'd0);
    assign unit_ready = !pipeLive;
    assign unitXfer   = unit_valid && unit_ready;
    assign unitLoses  = unit_valid && !unit_ready;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order of the always_ff blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_num  <= 5'd0;
            wr_data <= 32'd0;
            wr_pc   <= 32'd0;
        end else if (pipeLive) begin
            wr_en   <= 1'b1;
            wr_num  <= pipe_rd;
            wr_data <= pipe_data;
            wr_pc   <= pipe_pc;
        end else if (unitXfer && (unit_rd != 5'd0)) begin
            wr_en   <= 1'b1;
            wr_num  <= unit_rd;
            wr_data <= unit_data;
            wr_pc   <= unit_pc;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt   <= 4'd0;
            pipe_hold <= 1'b0;
        end else if (unitLoses && (waitCnt == HOLD_AT)) begin
            waitCnt   <= 4'd0;
            pipe_hold <= 1'b1;
        end else if (unitLoses) begin
            waitCnt   <= waitCnt + 4'd1;
            pipe_hold <= 1'b0;
        end else begin
            waitCnt   <= 4'd0;
            pipe_hold <= 1'b0;
        end
    end

    // Bit 0 of busy is never set, so x0 always reads as free.
    // NOTE: busyNext is defaulted first so no path through this block infers a latch.
    always_comb begin
        busyNext = busy;
        if (unitXfer && (unit_rd != 5'd0)) begin
            busyNext[unit_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busyNext[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 32'd0;
        end else begin
            busy <= busyNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky <= 1'b0;
        end else if (pipeLive && (pipe_hold || busy[pipe_rd])) begin
            err_sticky <= 1'b1;
        end
    end

    assign rs0_busy = (rs0 != 5'd0) && busy[rs0];
    assign rs1_busy = (rs1 != 5'd0) && busy[rs1];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios with a write-port scoreboard for reg_write_arbiter.
module tb_reg_write_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        unit_valid;
    logic        unit_ready;
    logic [4:0]  unit_rd;
    logic [31:0] unit_data;
    logic [31:0] unit_pc;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        rs0_busy;
    logic        rs1_busy;
    logic        pipe_hold;
    logic        wr_en;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic        err_sticky;

    typedef struct packed {
        logic        en;
        logic [4:0]  num;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t         expQ[$];
    logic [4:0]  lastNum;
    logic [31:0] lastData;
    logic [31:0] lastPc;
    int          numCompared = 0;
    int          numMismatched = 0;

    reg_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
        .unit_valid(unit_valid), .unit_ready(unit_ready),
        .unit_rd(unit_rd), .unit_data(unit_data), .unit_pc(unit_pc),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs0(rs0), .rs1(rs1), .rs0_busy(rs0_busy), .rs1_busy(rs1_busy),
        .pipe_hold(pipe_hold),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data), .wr_pc(wr_pc),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: predict the port winner from the driven inputs, then compare after the edge.
    task automatic tick(input string tag);
        wr_t  e;
        wr_t  g;
        logic live;
        #1;
        live = pipe_we && (pipe_rd != 5'd0);
        check({tag, ":unit_ready"}, 128'(unit_ready), 128'(!live));
        if (live)
            e = '{1'b1, pipe_rd, pipe_data, pipe_pc};
        else if (unit_valid && (unit_rd != 5'd0))
            e = '{1'b1, unit_rd, unit_data, unit_pc};
        else
            e = '{1'b0, lastNum, lastData, lastPc};
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            check({tag, ":scoreboard_empty"}, 128'(1), 128'(0));
        end else begin
            e = expQ.pop_front();
            g = '{wr_en, wr_num, wr_data, wr_pc};
            check({tag, ":wr"}, 128'(g), 128'(e));
            if (e.en) begin
                lastNum  = e.num;
                lastData = e.data;
                lastPc   = e.pc;
            end
        end
    endtask

    task automatic idle();
        pipe_we     = 1'b0;
        unit_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic starve(input logic [4:0] unitRd, input logic [4:0] firstRd);
        unit_valid = 1'b1;
        unit_rd    = unitRd;
        unit_data  = 32'hC000_0000 | 32'(unitRd);
        unit_pc    = 32'h800 + 32'(unitRd);
        pipe_we    = 1'b1;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            pipe_rd   = firstRd + 5'(i);
            pipe_data = 32'hA000_0000 + 32'(i);
            pipe_pc   = 32'h400 + 32'(4 * i);
            tick("starve_loss");
            check("starve_hold", 128'(pipe_hold), 128'(i == STARVE_LIMIT - 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        pipe_rd = 0; pipe_data = 0; pipe_pc = 0;
        unit_rd = 0; unit_data = 0; unit_pc = 0;
        issue_rd = 0; rs0 = 0; rs1 = 0;
        lastNum = 0; lastData = 0; lastPc = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", 128'({wr_en, wr_num, wr_data, wr_pc}), 128'(0));
        check("rst_hold", 128'(pipe_hold), 128'(0));
        check("rst_err", 128'(err_sticky), 128'(0));
        check("rst_ready", 128'(unit_ready), 128'(1));
        reset = 1'b1;

        // Pipeline-only write
        pipe_we = 1'b1; pipe_rd = 5; pipe_data = 32'hDEADBEEF; pipe_pc = 32'h100;
        tick("pipe_x5");

        // Write to x0 is dropped; port stays free for the unit
        pipe_rd = 0; pipe_data = 32'h1234_5678; pipe_pc = 32'h104;
        tick("pipe_x0");

        // Collision: pipe x3 wins, unit x7 follows next free cycle
        pipe_rd = 3; pipe_data = 32'h3333; pipe_pc = 32'h200;
        unit_valid = 1'b1; unit_rd = 7; unit_data = 32'h7777; unit_pc = 32'h300;
        tick("collide");
        pipe_we = 1'b0;
        tick("unit_x7");
        idle();
        tick("idle_a");

        // Unit result for x0: handshake completes, no write
        unit_valid = 1'b1; unit_rd = 0; unit_data = 32'hBAD0; unit_pc = 32'h310;
        tick("unit_x0");
        idle();

        // Scoreboard: issue x9, then set and clear of x10 in one cycle
        issue_valid = 1'b1; issue_rd = 9;
        tick("issue_x9");
        issue_valid = 1'b0;
        rs0 = 9; rs1 = 0;
        #1;
        check("busy_x9", 128'(rs0_busy), 128'(1));
        check("busy_rs1_x0", 128'(rs1_busy), 128'(0));
        issue_valid = 1'b1; issue_rd = 10;
        unit_valid = 1'b1; unit_rd = 10; unit_data = 32'h1010; unit_pc = 32'h320;
        tick("set_wins");
        idle();
        rs1 = 10;
        #1;
        check("busy_set_wins", 128'(rs1_busy), 128'(1));
        unit_valid = 1'b1; unit_rd = 9; unit_data = 32'h9999; unit_pc = 32'h330;
        tick("unit_x9");
        check("busy_x9_clear", 128'(rs0_busy), 128'(0));
        unit_rd = 10; unit_data = 32'h1011; unit_pc = 32'h334;
        tick("unit_x10");
        idle();
        check("busy_x10_clear", 128'(rs1_busy), 128'(0));
        rs0 = 0;
        #1;
        check("busy_rs0_x0", 128'(rs0_busy), 128'(0));

        // Starvation: hold after the 4th loss, pipeline idles, unit takes the hold cycle
        starve(5'd12, 5'd1);
        pipe_we = 1'b0;
        tick("hold_cycle");
        check("hold_done", 128'(pipe_hold), 128'(0));
        check("starve_no_err", 128'(err_sticky), 128'(0));
        idle();
        tick("idle_b");

        // Pipeline ignores the hold: it still wins and raises the error
        starve(5'd13, 5'd16);
        pipe_rd = 14; pipe_data = 32'h1414; pipe_pc = 32'h500;
        tick("hold_violate");
        check("hold_err", 128'(err_sticky), 128'(1));
        pipe_we = 1'b0;
        tick("unit_x13");
        idle();
        check("hold_cleared", 128'(pipe_hold), 128'(0));

        // Reset mid-operation with busy bits set and a write pending
        issue_valid = 1'b1; issue_rd = 20;
        tick("issue_x20");
        issue_valid = 1'b0;
        rs0 = 20;
        #1;
        check("busy_x20", 128'(rs0_busy), 128'(1));
        pipe_we = 1'b1; pipe_rd = 22; pipe_data = 32'h2222; pipe_pc = 32'h600;
        tick("pre_rst");
        pipe_rd = 23; pipe_data = 32'h2323; pipe_pc = 32'h604;
        unit_valid = 1'b1; unit_rd = 20; unit_data = 32'h2020; unit_pc = 32'h608;
        reset = 1'b0;
        #1;
        check("rst_mid_wr", 128'({wr_en, wr_num, wr_data, wr_pc}), 128'(0));
        check("rst_mid_hold", 128'(pipe_hold), 128'(0));
        check("rst_mid_err", 128'(err_sticky), 128'(0));
        check("rst_mid_busy", 128'(rs0_busy), 128'(0));
        check("rst_mid_ready", 128'(unit_ready), 128'(0));
        @(posedge clk);
        #1;
        check("rst_mid_held", 128'(wr_en), 128'(0));
        idle();
        reset = 1'b1;
        expQ.delete();
        lastNum = 0; lastData = 0; lastPc = 0;
        tick("post_rst_a");
        tick("post_rst_b");

        // WAW hazard: pipeline write to a busy register is performed and flagged
        issue_valid = 1'b1; issue_rd = 9;
        tick("issue_x9b");
        issue_valid = 1'b0;
        pipe_we = 1'b1; pipe_rd = 9; pipe_data = 32'h0909; pipe_pc = 32'h700;
        tick("waw_x9");
        check("waw_err", 128'(err_sticky), 128'(1));
        idle();
        tick("idle_c");
        check("err_sticks", 128'(err_sticky), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
